seg7_scan_driver: RTL

- Output-side counterpart to the board's input debouncers: drives a CPU-written value onto the board's multiplexed 8-digit seven-segment display.
- Latches a 32-bit hex value from the CPU MMIO write path and scans it onto active-low anode/cathode pins.
- Provides an inter-digit blanking interval against ghosting, and tear-free updates at frame boundaries.

---
 rtl/seg7_scan_driver_pkg.sv | 20 ++
 rtl/seg7_scan_driver_if.sv | 22 ++
 rtl/seg7_scan_driver_hex_to_seg7.sv | 11 +
 rtl/seg7_scan_driver.sv | 121 ++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and types for the seven-segment scan driver: hex font,
// "all off" pin levels and the frame buffer record.
package seg7_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   // gfedcba, active-high; element n is the glyph for hex digit n.
   localparam logic [15:0][6:0] HEX_FONT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  dp;
      logic [7:0]  en;
   } frame_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// CPU-side load port and display pins of the seven-segment scan driver.
interface seg7_scan_driver_if;

   logic        load;
   logic [31:0] data;
   logic [7:0]  dp;
   logic [7:0]  digit_en;
   logic [7:0]  seg_an;
   logic [7:0]  seg_cat;
   logic        frame_done;

   modport master (
      output load, data, dp, digit_en,
      input  seg_an, seg_cat, frame_done
   );

   modport slave (
      input  load, data, dp, digit_en,
      output seg_an, seg_cat, frame_done
   );

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to gfedcba segment decoder (active-high segments).
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit seven-segment scanner with inter-digit blanking and
// frame-synchronous double buffering. Optional: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV     = 100_000,
   parameter int BLANK_CYCLES = 1_000,
   parameter int NUM_DIGITS   = 8
) (
   input  logic                clk,
   input  logic                rst,
   seg7_scan_driver_if.slave   bus
);

   localparam int          CNT_W    = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
   localparam logic [2:0]  LAST_IDX = 3'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] slot_cnt;
   logic [2:0]       idx;
   logic             pending;
   frame_t           shadow;
   frame_t           disp;
   frame_t           load_val;

   logic [7:0] seg_an_q;
   logic [7:0] seg_cat_q;
   logic       frame_done_q;

   logic       frame_wrap;
   logic       blank;
   logic       show;
   logic [3:0] cur_nibble;
   logic [6:0] cur_font;
   logic [7:0] an_sel;
   logic [7:0] lz_dark;

   assign load_val   = '{data: bus.data, dp: bus.dp, en: bus.digit_en};
   assign frame_wrap = (slot_cnt == LAST_CNT) && (idx == LAST_IDX);
   assign blank      = (slot_cnt < BLANK_END);
   assign cur_nibble = disp.data[{idx, 2'b00} +: 4];
   assign an_sel     = ~(8'b1 << idx);
   assign show       = !blank && disp.en[idx] && !lz_dark[idx];

   hex_to_seg7 u_font (
      .nibble (cur_nibble),
      .seg    (cur_font)
   );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // Walk from the top digit down; a digit is a leading zero when it and every
   // enabled digit above it hold 0. Digit 0 is never blanked.
   always_comb begin
      logic zero_above;
      // NOTE: every variable gets a default before the loop so no latch is inferred.
      lz_dark    = '0;
      zero_above = 1'b1;
      for (int k = 7; k >= 1; k--) begin
         if (k < NUM_DIGITS) begin
            lz_dark[k] = zero_above && (disp.data[4*k +: 4] == 4'h0);
            zero_above = zero_above && (!disp.en[k] || (disp.data[4*k +: 4] == 4'h0));
         end
      end
   end
`else
   assign lz_dark = '0;
`endif

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt     <= '0;
         idx          <= '0;
         pending      <= 1'b0;
         shadow       <= '0;
         disp         <= '0;
         seg_an_q     <= AN_OFF;
         seg_cat_q    <= SEG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (slot_cnt == LAST_CNT) begin
            slot_cnt <= '0;
            if (idx == LAST_IDX) begin
               idx          <= '0;
               frame_done_q <= 1'b1;
            end else begin
               idx <= idx + 3'd1;
            end
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end

         // Display only changes at the frame boundary; a load landing exactly
         // on the boundary bypasses the shadow so it is never a frame late.
         if (bus.load) begin
            shadow <= load_val;
         end
         if (frame_wrap) begin
            pending <= 1'b0;
            if (bus.load) begin
               disp <= load_val;
            end else if (pending) begin
               disp <= shadow;
            end
         end else if (bus.load) begin
            pending <= 1'b1;
         end

         seg_an_q  <= show  ? an_sel  : AN_OFF;
         seg_cat_q <= blank ? SEG_OFF : ~{disp.dp[idx], cur_font};
      end
   end

   assign bus.seg_an     = seg_an_q;
   assign bus.seg_cat    = seg_cat_q;
   assign bus.frame_done = frame_done_q;

endmodule
